// File: rtl/mux_scan_driver_pkg.sv
// Shared definitions for the display/pushbutton mux scan: state encodings, default timing, segment bit order.
// The default timing values are also used by the pushbutton receiver.
package mux_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int DEF_MUX_NOD      = 6;
  localparam int DEF_DWELL_CYCLES = 10000;
  localparam int DEF_BLANK_CYCLES = 100;

  // Segment byte layout, MSB first: {dp, g, f, e, d, c, b, a}, all active-high.
  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  function automatic int timer_width(input int dwell, input int blank);
    return $clog2((dwell > blank) ? dwell : blank) + 1;
  endfunction

endpackage

// File: rtl/mux_scan_driver_if.sv
// Bus between the display data register, the scan driver and the board pins.
// master = scan driver side; duty exists only when MUX_SCAN_DIM_EN is defined.
interface mux_scan_driver_if #(
  parameter int MUX_NOD = mux_scan_driver_pkg::DEF_MUX_NOD
);
  import mux_scan_driver_pkg::*;

  logic                 en;
  logic [8*MUX_NOD-1:0] digits_in;
  logic [MUX_NOD-1:0]   muxout;
  seg_t                 seg;
  logic                 frame_done;
  logic [2:0]           cur_idx;

`ifdef MUX_SCAN_DIM_EN
  logic [3:0]           duty;

  modport master (input en, digits_in, duty, output muxout, seg, frame_done, cur_idx);
  modport slave  (output en, digits_in, duty, input muxout, seg, frame_done, cur_idx);
`else
  modport master (input en, digits_in, output muxout, seg, frame_done, cur_idx);
  modport slave  (output en, digits_in, input muxout, seg, frame_done, cur_idx);
`endif

endinterface

// File: rtl/mux_scan_driver_scan_timer.sv
// Loadable saturating down-counter; zero is high while the count is 0.
// The raw count is exported only for the dimming build (MUX_SCAN_DIM_EN).
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
`ifdef MUX_SCAN_DIM_EN
  ,
  output logic [W-1:0] count
`endif
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

`ifdef MUX_SCAN_DIM_EN
  assign count = cnt;
`endif

endmodule

// File: rtl/mux_scan_driver.sv
// Drives one mux line at a time with blank gaps between lines and a per-digit snapshot of the segment data.
// MUX_SCAN_DIM_EN adds bus.duty, which cuts seg early in each dwell while the mux line stays high.
module mux_scan_driver
  import mux_scan_driver_pkg::*;
#(
  parameter int MUX_NOD      = DEF_MUX_NOD,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  mux_scan_driver_if.master bus
);

  localparam int            TW         = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(MUX_NOD - 1);

  scan_state_t        state, state_nxt;
  logic [MUX_NOD-1:0] muxout_q, muxout_nxt;
  seg_t               seg_q, seg_nxt;
  logic               frame_done_q, frame_done_nxt;
  logic [2:0]         idx_q, idx_nxt;

  logic               tmr_load;
  logic [TW-1:0]      tmr_load_val;
  logic               tmr_zero;
  seg_t               digit_sel;

  assign digit_sel = seg_t'(bus.digits_in[8*idx_q +: 8]);

`ifdef MUX_SCAN_DIM_EN
  seg_t          snap_q, snap_nxt;
  logic [TW-1:0] tmr_count;
  int            dim_thr;

  // seg is cut once elapsed dwell cycles reach this threshold
  assign dim_thr = ((int'(bus.duty) + 1) * DWELL_CYCLES) / 16;
`endif

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
`ifdef MUX_SCAN_DIM_EN
    ,
    .count    (tmr_count)
`endif
  );

  always_comb begin
    state_nxt      = state;
    muxout_nxt     = muxout_q;
    seg_nxt        = seg_q;
    frame_done_nxt = 1'b0;
    idx_nxt        = idx_q;
    tmr_load       = 1'b0;
    tmr_load_val   = BLANK_LOAD;
`ifdef MUX_SCAN_DIM_EN
    snap_nxt       = snap_q;
`endif
    case (state)
      IDLE: begin
        muxout_nxt = '0;
        seg_nxt    = '0;
        idx_nxt    = '0;
        if (bus.en) begin
          state_nxt    = BLANK;
          tmr_load     = 1'b1;
          tmr_load_val = BLANK_LOAD;
        end
      end
      BLANK: begin
        muxout_nxt = '0;
        seg_nxt    = '0;
        if (!bus.en) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (tmr_zero) begin
          state_nxt    = DRIVE;
          tmr_load     = 1'b1;
          tmr_load_val = DWELL_LOAD;
          muxout_nxt   = MUX_NOD'(1) << idx_q;
`ifdef MUX_SCAN_DIM_EN
          snap_nxt     = digit_sel;
          seg_nxt      = (dim_thr > 0) ? digit_sel : '0;
`else
          seg_nxt      = digit_sel;
`endif
        end
      end
      DRIVE: begin
        if (!bus.en) begin
          state_nxt  = IDLE;
          muxout_nxt = '0;
          seg_nxt    = '0;
          idx_nxt    = '0;
        end else if (tmr_zero) begin
          state_nxt    = BLANK;
          tmr_load     = 1'b1;
          tmr_load_val = BLANK_LOAD;
          muxout_nxt   = '0;
          seg_nxt      = '0;
          if (idx_q == LAST_IDX) begin
            idx_nxt        = '0;
            frame_done_nxt = 1'b1;
          end else begin
            idx_nxt = idx_q + 3'd1;
          end
        end else begin
`ifdef MUX_SCAN_DIM_EN
          // elapsed count after this edge is DWELL_CYCLES - current timer value
          seg_nxt = ((DWELL_CYCLES - int'(tmr_count)) < dim_thr) ? snap_q : '0;
`endif
        end
      end
      default: begin
        state_nxt  = IDLE;
        muxout_nxt = '0;
        seg_nxt    = '0;
        idx_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      muxout_q     <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      state        <= state_nxt;
      muxout_q     <= muxout_nxt;
      seg_q        <= seg_nxt;
      frame_done_q <= frame_done_nxt;
      idx_q        <= idx_nxt;
    end
  end

`ifdef MUX_SCAN_DIM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_nxt;
    end
  end
`endif

  assign bus.muxout     = muxout_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cur_idx    = idx_q;

endmodule
